// File: rtl/sd_block_buffer.sv
// Single-block (512-byte) read buffer between a memory bus and an SD block reader.
// Optional macro SD_BLOCK_BUFFER_STATS_EN adds a saturating 16-bit miss_count output.
module sd_block_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] address,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        rd_req,
  output logic [14:0] rd_block,
  input  logic        rd_byte_valid,
  input  logic [7:0]  rd_byte,
  input  logic        rd_error,
  output logic [7:0]  load_count
`ifdef SD_BLOCK_BUFFER_STATS_EN
  ,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQUEST, FILL} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [14:0] tag_q, tag_d;
  logic [8:0]  fill_idx_q, fill_idx_d;
  logic [14:0] rd_block_q, rd_block_d;
  logic [7:0]  load_count_q, load_count_d;
  logic        buf_we;
  logic        hit;
  logic [7:0]  buffer_q [512];

`ifdef SD_BLOCK_BUFFER_STATS_EN
  logic [15:0] miss_count_q, miss_count_d;
`endif

  // A hit is only honoured in IDLE so a fill in progress never serves stale data.
  assign hit        = valid_q && (tag_q == address[23:9]) && (state_q == IDLE);
  assign data_out   = hit ? buffer_q[address[8:0]] : 8'h00;
  assign busy       = (enable && !hit) || (state_q != IDLE);
  assign rd_req     = (state_q == REQUEST);
  assign rd_block   = rd_block_q;
  assign load_count = load_count_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    fill_idx_d   = fill_idx_q;
    rd_block_d   = rd_block_q;
    load_count_d = load_count_q;
    buf_we       = 1'b0;
`ifdef SD_BLOCK_BUFFER_STATS_EN
    miss_count_d = miss_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && !hit) begin
          rd_block_d = address[23:9];
          valid_d    = 1'b0;
          fill_idx_d = 9'd0;
          state_d    = REQUEST;
`ifdef SD_BLOCK_BUFFER_STATS_EN
          if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
`endif
        end
      end
      REQUEST: state_d = FILL;
      FILL: begin
        // An error wins over a byte arriving in the same cycle.
        if (rd_error) begin
          state_d = IDLE;
        end else if (rd_byte_valid) begin
          buf_we     = 1'b1;
          fill_idx_d = fill_idx_q + 9'd1;
          if (fill_idx_q == 9'd511) begin
            tag_d        = rd_block_q;
            valid_d      = 1'b1;
            load_count_d = load_count_q + 8'd1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      tag_q        <= 15'd0;
      fill_idx_q   <= 9'd0;
      rd_block_q   <= 15'd0;
      load_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      fill_idx_q   <= fill_idx_d;
      rd_block_q   <= rd_block_d;
      load_count_q <= load_count_d;
    end
  end

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && buf_we) buffer_q[fill_idx_q] <= rd_byte;
  end

`ifdef SD_BLOCK_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) miss_count_q <= 16'd0;
    else        miss_count_q <= miss_count_d;
  end
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_sd_block_buffer.sv
// Self-checking bench for sd_block_buffer: fills, hits, read errors, mid-fill reset and surplus bytes.
module tb_sd_block_buffer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [23:0] address;
  logic [7:0]  data_out;
  logic        busy;
  logic        rd_req;
  logic [14:0] rd_block;
  logic        rd_byte_valid;
  logic [7:0]  rd_byte;
  logic        rd_error;
  logic [7:0]  load_count;
`ifdef SD_BLOCK_BUFFER_STATS_EN
  logic [15:0] miss_count;
`endif

  sd_block_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .address       (address),
    .data_out      (data_out),
    .busy          (busy),
    .rd_req        (rd_req),
    .rd_block      (rd_block),
    .rd_byte_valid (rd_byte_valid),
    .rd_byte       (rd_byte),
    .rd_error      (rd_error),
    .load_count    (load_count)
`ifdef SD_BLOCK_BUFFER_STATS_EN
    ,
    .miss_count    (miss_count)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int req_seen = 0;
  int exp_req = 0;
  logic [7:0] model_buf [512];
  logic [7:0] exp_q [$];

  always @(posedge clk) if (reset && rd_req === 1'b1) req_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a miss and follow it until the request strobe; leaves the DUT in FILL.
  task automatic start_miss(input logic [23:0] addr);
    logic seen;
    enable  = 1'b1;
    address = addr;
    #1;
    check_eq("miss_busy", busy, 1);
    check_eq("miss_no_req_yet", rd_req, 0);
    check_eq("miss_data_zero", data_out, 0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      if (rd_req) seen = 1'b1;
    end
    exp_req++;
    check_eq("rd_req_seen", seen, 1);
    check_eq("rd_block", rd_block, addr[23:9]);
    step();
    check_eq("rd_req_one_cycle", rd_req, 0);
  endtask

  // Feed n bytes; kind selects the value pattern. Only full fills update the model.
  task automatic feed(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      case (kind)
        0:       v = i[7:0];
        1:       v = ~i[7:0];
        2:       v = i[7:0] * 8'd3;
        default: v = i[7:0] ^ 8'h5A;
      endcase
      rd_byte_valid = 1'b1;
      rd_byte       = v;
      if (n == 512) model_buf[i] = v;
      if (i == 0 || i == 256) begin
        #1;
        check_eq("fill_busy", busy, 1);
        check_eq("fill_data_zero", data_out, 0);
      end
      step();
    end
    rd_byte_valid = 1'b0;
  endtask

  // Scoreboard read: expected byte queued at drive time, compared when the DUT answers.
  task automatic read_hit(input logic [14:0] blk, input logic [8:0] off);
    enable  = 1'b1;
    address = {blk, off};
    exp_q.push_back(model_buf[off]);
    #1;
    check_eq("hit_data", data_out, exp_q.pop_front());
    check_eq("hit_busy", busy, 0);
    step();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; address = 24'd0;
    rd_byte_valid = 1'b0; rd_byte = 8'd0; rd_error = 1'b0;
    repeat (2) step();
    check_eq("rst_rd_req", rd_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_block", rd_block, 0);
    check_eq("rst_load_count", load_count, 0);
    check_eq("rst_data", data_out, 0);
    reset = 1'b1;
    step();

    // first fill of block 0x0060
    start_miss(24'h00C000);
    feed(512, 0);
    address = 24'h00C000;
    #1;
    check_eq("busy_drop_after_511", busy, 0);
    check_eq("load_count_1", load_count, 1);
    check_eq("req_count_a", req_seen, exp_req);
    read_hit(15'h0060, 9'h005);
    read_hit(15'h0060, 9'h000);
    read_hit(15'h01FF & 15'h0060, 9'h1FF);
    for (int i = 0; i < 6; i++) read_hit(15'h0060, 9'($urandom_range(0, 511)));

    // surplus bytes with enable low are ignored
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_byte_valid = 1'b1;
      rd_byte       = 8'hAA;
      #1;
      check_eq("idle_busy_low", busy, 0);
      step();
    end
    rd_byte_valid = 1'b0;
    check_eq("surplus_no_req", req_seen, exp_req);
    for (int i = 0; i < 4; i++) read_hit(15'h0060, 9'($urandom_range(0, 511)));

    // block 0x0061 with a read error after 100 bytes (error wins over a valid byte)
    start_miss(24'h00C200);
    feed(100, 1);
    rd_error = 1'b1; rd_byte_valid = 1'b1; rd_byte = 8'hEE;
    step();
    rd_error = 1'b0; rd_byte_valid = 1'b0;
    check_eq("err_load_count", load_count, 1);
    start_miss(24'h00C200);
    check_eq("retry_req_count", req_seen, exp_req);
    feed(512, 2);
    #1;
    check_eq("load_count_2", load_count, 2);
    read_hit(15'h0061, 9'h000);
    read_hit(15'h0061, 9'h064);
    read_hit(15'h0061, 9'h1FF);
    enable  = 1'b0;
    address = 24'h00C005;
    #1;
    check_eq("old_block_miss_data", data_out, 0);
    check_eq("old_block_idle_busy", busy, 0);
    step();

    // reset in the middle of a fill
    start_miss(24'h012345);
    feed(300, 3);
    reset = 1'b0; enable = 1'b0; rd_byte_valid = 1'b1; rd_byte = 8'h11;
    step();
    check_eq("midrst_rd_req", rd_req, 0);
    check_eq("midrst_load_count", load_count, 0);
    check_eq("midrst_busy", busy, 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd_byte_valid = 1'b1;
      rd_byte       = 8'h22;
      step();
    end
    rd_byte_valid = 1'b0;
    check_eq("post_rst_no_req", req_seen, exp_req);
    address = 24'h012345;
    #1;
    check_eq("post_rst_no_hit", data_out, 0);
    start_miss(24'h012345);
    feed(512, 3);
    #1;
    check_eq("fresh_load_count", load_count, 1);
    read_hit(15'h0091, 9'h145);
    read_hit(15'h0091, 9'h000);
    read_hit(15'h0091, 9'h1FF);
    check_eq("final_req_count", req_seen, exp_req);
`ifdef SD_BLOCK_BUFFER_STATS_EN
    check_eq("miss_count", miss_count, 1);
`endif
    if (exp_q.size() != 0) check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_block_buffer.md
SD_BLOCK_BUFFER -- requirements
Module: sd_block_buffer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  reset; synchronous and active-low.
REQ-003 SHALL have port enable  input  1  bus request for cartridge space, from the memory bus.
REQ-004 SHALL have port address  input  24  byte address; [23:9] is the block number, [8:0] is the byte offset.
REQ-005 SHALL have port data_out  output  8  read data to the memory bus.
REQ-006 SHALL have port busy  output  1  stall request to the memory bus.
REQ-007 SHALL have port rd_req  output  1  one-cycle block-read strobe to the SD reader.
REQ-008 SHALL have port rd_block  output  15  block number being fetched.
REQ-009 SHALL have port rd_byte_valid  input  1  rd_byte carries the next sequential byte.
REQ-010 SHALL have port rd_byte  input  8  fetched byte.
REQ-011 SHALL have port rd_error  input  1  SD reader aborted the block.
REQ-012 SHALL have port load_count  output  8  completed block fills, modulo 256.

Function
REQ-013 SHALL hold a 512x8 buffer array, a 15-bit tag, a valid bit, a 9-bit fill index and the states IDLE, REQUEST and FILL.
REQ-014 SHALL define hit as valid, tag == address[23:9] and state == IDLE.
REQ-015 SHALL drive data_out = buffer[address[8:0]] combinationally on a hit and 0x00 otherwise, giving zero-cycle hit latency.
REQ-016 SHALL drive busy = (enable && !hit) || state != IDLE.
REQ-017 In IDLE with enable and no hit, SHALL: latch rd_block = address[23:9], clear valid, zero the fill index and enter REQUEST.
REQ-018 In IDLE with enable low, SHALL issue no request and leave the buffer unchanged.
REQ-019 In REQUEST, SHALL assert rd_req for exactly one cycle and then enter FILL.
REQ-020 In FILL, on each rd_byte_valid, SHALL write rd_byte to buffer[fill index] and increment the fill index.
REQ-021 On the byte written at index 511, SHALL: set tag = rd_block, set valid, increment load_count (wrapping 255->0) and enter IDLE.
REQ-022 SHALL ignore rd_byte_valid outside FILL, so surplus bytes never corrupt the buffer.
REQ-023 On rd_error in FILL, SHALL keep valid = 0, leave load_count unchanged and enter IDLE; the retry follows from REQ-017 if enable and the miss persist.
REQ-024 If rd_error and rd_byte_valid arrive in the same cycle, SHALL give rd_error priority and not write the byte.
REQ-025 SHALL ignore changes to address and enable during REQUEST and FILL; the latched rd_block governs the fill, and the hit is re-evaluated on return to IDLE.
REQ-026 SHALL never issue a second rd_req before the current fill completes or errors.

Reset
REQ-027 While reset is low at a clock edge, SHALL set: state = IDLE, valid = 0, tag = 0, fill index = 0, rd_req = 0, rd_block = 0, load_count = 0.
REQ-028 Buffer contents SHALL be undefined after reset and SHALL NOT be cleared.
REQ-029 Reset asserted mid-fill SHALL abandon the fill with no tag update.
REQ-030 With valid = 0 after reset, data_out SHALL be 0x00.

Configuration
REQ-031 Macro SD_BLOCK_BUFFER_STATS_EN, when defined, SHALL add output miss_count (16 bits): increments on each IDLE->REQUEST transition, saturates at 0xFFFF and resets to 0.
REQ-032 Without SD_BLOCK_BUFFER_STATS_EN, the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset low 2 cycles, then enable = 1, address = 0x00C000 -> busy = 1, rd_req pulses once with rd_block = 0x0060, data_out = 0x00 while filling.
REQ-034 Feed 512 bytes (value = index[7:0]) -> busy drops the cycle after byte 511, load_count = 1; address 0x00C005 then reads 0x05 with busy = 0 the same cycle.
REQ-035 After the fill, address = 0x00C200 -> new rd_req with rd_block = 0x0061; inject rd_error after 100 bytes -> valid stays 0, load_count stays 1, rd_req re-issues on the next IDLE cycle.
REQ-036 Assert reset at byte 300 of a fill -> state IDLE, rd_req 0, load_count 0; bytes arriving afterwards are ignored; a re-access starts a fresh fill.
REQ-037 After a completed fill, drive 10 extra rd_byte_valid pulses with enable low -> buffer unchanged, no rd_req.
REQ-038 With SD_BLOCK_BUFFER_STATS_EN defined, 3 misses -> miss_count = 3; preloading 0xFFFF and missing again -> 0xFFFF.
